dmem_access_ctrl: RTL and testbench

//  Sequences the Y86 memory stage onto a single-ported, variable-latency data memory.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/dmem_access_ctrl_if.sv | 21 ++
 rtl/dmem_timeout_timer.sv | 28 ++
 rtl/dmem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants, FSM encoding and memory-command payload for the data-memory access path.
package y86_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned ICODE_W = 4;

    localparam logic [ICODE_W-1:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] ICODE_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] ICODE_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] ICODE_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } dmem_cmd_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge bus between the memory-stage controller and the data memory.
interface dmem_access_ctrl_if;

    logic                           mem_req;
    logic                           mem_we;
    logic [y86_pkg::WORD_W-1:0]     mem_addr;
    logic [y86_pkg::WORD_W-1:0]     mem_wdata;
    logic [y86_pkg::WORD_W-1:0]     mem_rdata;
    logic                           mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/dmem_timeout_timer.sv
// Counts cycles while enabled; expire_c flags the last permitted cycle (count == TIMEOUT-1).
module dmem_timeout_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire_c = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Y86 memory stage sequencer: decodes icode into a single read/write on a req/ack data memory
// with bounds check and ack timeout, returning valM/dmem_error with a one-cycle done pulse.
module dmem_access_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ICODE_W-1:0]  icode,
    input  logic [WORD_W-1:0]   valA,
    input  logic [WORD_W-1:0]   valE,
    input  logic [WORD_W-1:0]   valP,
    output logic                busy,
    output logic                done,
    output logic [WORD_W-1:0]   valM,
    output logic                dmem_error,
    dmem_access_ctrl_if.master  mem
);

    state_e            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_req;
    logic              r_we;
    logic              r_err;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_valm;

    state_e            w_state_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_req_nxt;
    logic              w_we_nxt;
    logic              w_err_nxt;
    logic [WORD_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] w_wdata_nxt;
    logic [WORD_W-1:0] w_valm_nxt;

    dmem_cmd_t         w_cmd;
    logic              w_has_access;
    logic              w_oob;
    logic              w_tmr_clear;
    logic              w_tmr_en;
    logic              w_expire_c;

    // Access decode: which icodes touch memory, and where the address/data come from.
    always_comb begin
        w_cmd        = '0;
        w_has_access = 1'b0;
        case (icode)
            ICODE_RMMOVQ, ICODE_PUSHQ: begin
                w_has_access = 1'b1;
                w_cmd.we     = 1'b1;
                w_cmd.addr   = valE;
                w_cmd.wdata  = valA;
            end
            ICODE_CALL: begin
                w_has_access = 1'b1;
                w_cmd.we     = 1'b1;
                w_cmd.addr   = valE;
                w_cmd.wdata  = valP;
            end
            ICODE_MRMOVQ: begin
                w_has_access = 1'b1;
                w_cmd.addr   = valE;
            end
            ICODE_RET, ICODE_POPQ: begin
                w_has_access = 1'b1;
                w_cmd.addr   = valA;
            end
            default: begin
                w_has_access = 1'b0;
            end
        endcase
    end

    // 65-bit sum so addresses near 2^64 cannot wrap into range.
    assign w_oob = (({1'b0, w_cmd.addr} + 65'd8) > 65'(MEM_BYTES));

    dmem_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_tmr_clear),
        .i_enable   (w_tmr_en),
        .o_expire_c (w_expire_c)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_err_nxt   = r_err;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_valm_nxt  = r_valm;
        w_tmr_clear = 1'b1;
        w_tmr_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    w_valm_nxt = '0;
                    w_err_nxt  = 1'b0;
                    if (!w_has_access) begin
                        w_state_nxt = ST_FINISH;
                        w_done_nxt  = 1'b1;
                    end else if (w_oob) begin
                        w_state_nxt = ST_FINISH;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = w_cmd.we;
                        w_addr_nxt  = w_cmd.addr;
                        w_wdata_nxt = w_cmd.wdata;
                    end
                end
            end

            ST_ACCESS: begin
                w_tmr_clear = 1'b0;
                w_tmr_en    = 1'b1;
                if (mem.mem_ack) begin
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = 1'b1;
                    w_req_nxt   = 1'b0;
                    if (!r_we) begin
                        w_valm_nxt = mem.mem_rdata;
                    end
                end else if (w_expire_c) begin
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_valm_nxt  = '0;
                end
            end

            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valm  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_err   <= w_err_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_valm  <= w_valm_nxt;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign valM          = r_valm;
    assign dmem_error    = r_err;
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (MEM_BYTES=1024, TIMEOUT=16).
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        busy;
    logic        done;
    logic [63:0] valM;
    logic        dmem_error;

    int n_cmp;
    int n_err;

    dmem_access_ctrl_if mem_if ();

    dmem_access_ctrl #(
        .MEM_BYTES (1024),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .busy       (busy),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error),
        .mem        (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access; ack_at is the cycle (counted from 1 after start) on which mem_ack is raised, 0 = never.
    task automatic do_op(input string tag, input logic [3:0] ic, input logic [63:0] a,
                         input logic [63:0] e, input logic [63:0] p, input int ack_at,
                         input logic [63:0] rdata, input bit exp_req, input bit exp_we,
                         input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                         input int exp_done_cyc, input logic [63:0] exp_valm, input bit exp_err,
                         input int exp_req_cycles, input bit pulse_start);
        int cyc;
        int req_cnt;
        int done_cyc;
        bit unstable;
        icode = ic; valA = a; valE = e; valP = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; req_cnt = 0; done_cyc = 0; unstable = 1'b0;
        check_eq({tag, ".busy1"}, 64'(busy), 64'd1);
        check_eq({tag, ".req1"}, 64'(mem_if.mem_req), 64'(exp_req));
        if (exp_req) begin
            check_eq({tag, ".addr"}, mem_if.mem_addr, exp_addr);
            check_eq({tag, ".we"}, 64'(mem_if.mem_we), 64'(exp_we));
            if (exp_we) check_eq({tag, ".wdata"}, mem_if.mem_wdata, exp_wdata);
        end
        while (done_cyc == 0 && cyc < 64) begin
            if (mem_if.mem_req) begin
                req_cnt++;
                if (mem_if.mem_addr !== exp_addr || mem_if.mem_we !== exp_we ||
                    (exp_we && mem_if.mem_wdata !== exp_wdata))
                    unstable = 1'b1;
            end
            if (done) begin
                done_cyc = cyc;
            end else begin
                mem_if.mem_ack   = (cyc == ack_at);
                mem_if.mem_rdata = rdata;
                start = pulse_start && (cyc == 2);
                if (start) icode = 4'h3;
                tick();
                start = 1'b0;
                mem_if.mem_ack = 1'b0;
                cyc++;
            end
        end
        check_eq({tag, ".done_cyc"}, 64'(done_cyc), 64'(exp_done_cyc));
        check_eq({tag, ".req_cycles"}, 64'(req_cnt), 64'(exp_req_cycles));
        if (exp_req) check_eq({tag, ".stable"}, 64'(unstable), 64'd0);
        check_eq({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        check_eq({tag, ".valM"}, valM, exp_valm);
        check_eq({tag, ".err"}, 64'(dmem_error), 64'(exp_err));
        tick();
        check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, ".busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, ".valM_hold"}, valM, exp_valm);
        check_eq({tag, ".err_hold"}, 64'(dmem_error), 64'(exp_err));
        if (pulse_start) begin
            tick();
            check_eq({tag, ".no_queue_busy"}, 64'(busy), 64'd0);
            check_eq({tag, ".no_queue_req"}, 64'(mem_if.mem_req), 64'd0);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        repeat (3) tick();
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.req", 64'(mem_if.mem_req), 64'd0);
        check_eq("rst.valM", valM, 64'd0);
        check_eq("rst.err", 64'(dmem_error), 64'd0);
        rst_n = 1'b1;
        tick();

        //      tag         ic     valA      valE                   valP   ack rdata    req we addr   wdata  done valM     err reqc pulse
        do_op("mrmovq",   4'h5, 64'd0,    64'd16,               64'd0,  3, 64'hDEAD, 1, 0, 64'd16, 64'd0,  4, 64'hDEAD, 0, 3, 0);
        do_op("rmmovq",   4'h4, 64'd15,   64'd2,                64'd0,  1, 64'hBAD,  1, 1, 64'd2,  64'd15, 2, 64'd0,    0, 1, 0);
        do_op("call",     4'h8, 64'd99,   64'd2,                64'd10, 2, 64'd0,    1, 1, 64'd2,  64'd10, 3, 64'd0,    0, 2, 0);
        do_op("popq",     4'hB, 64'd40,   64'd7,                64'd0,  1, 64'h1234, 1, 0, 64'd40, 64'd0,  2, 64'h1234, 0, 1, 0);
        do_op("irmovq",   4'h3, 64'd40,   64'd16,               64'd0,  1, 64'd0,    0, 0, 64'd0,  64'd0,  1, 64'd0,    0, 0, 0);
        do_op("ret_edge", 4'h9, 64'd1016, 64'd0,                64'd0,  2, 64'h77,   1, 0, 64'd1016, 64'd0, 3, 64'h77,  0, 2, 0);
        do_op("pushq",    4'hA, 64'h55,   64'd1016,             64'd0,  1, 64'd0,    1, 1, 64'd1016, 64'h55, 2, 64'd0,  0, 1, 0);
        do_op("oob_1020", 4'h5, 64'd0,    64'd1020,             64'd0,  1, 64'd0,    0, 0, 64'd0,  64'd0,  1, 64'd0,    1, 0, 0);
        do_op("oob_wrap", 4'h5, 64'd0,    64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1, 64'd0,  0, 0, 64'd0,  64'd0,  1, 64'd0,    1, 0, 0);
        do_op("oob_1017", 4'h4, 64'd1,    64'd1017,             64'd0,  1, 64'd0,    0, 0, 64'd0,  64'd0,  1, 64'd0,    1, 0, 0);
        do_op("timeout",  4'h5, 64'd0,    64'd8,                64'd0,  0, 64'd0,    1, 0, 64'd8,  64'd0, 17, 64'd0,    1, 16, 0);
        do_op("ack_last", 4'h5, 64'd0,    64'd8,                64'd0, 16, 64'hCAFE, 1, 0, 64'd8,  64'd0, 17, 64'hCAFE, 0, 16, 0);
        do_op("busy_start", 4'h5, 64'd0,  64'd24,               64'd0,  3, 64'hBEEF, 1, 0, 64'd24, 64'd0,  4, 64'hBEEF, 0, 3, 1);

        // A stray ack while idle must have no effect.
        mem_if.mem_ack = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0;
        check_eq("idle_ack.busy", 64'(busy), 64'd0);
        check_eq("idle_ack.done", 64'(done), 64'd0);
        check_eq("idle_ack.valM", valM, 64'hBEEF);

        // Reset in the middle of an access.
        icode = 4'hA; valA = 64'h99; valE = 64'd48; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("midrst.req_before", 64'(mem_if.mem_req), 64'd1);
        rst_n = 1'b0;
        tick();
        check_eq("midrst.req", 64'(mem_if.mem_req), 64'd0);
        check_eq("midrst.busy", 64'(busy), 64'd0);
        check_eq("midrst.we", 64'(mem_if.mem_we), 64'd0);
        check_eq("midrst.addr", mem_if.mem_addr, 64'd0);
        check_eq("midrst.wdata", mem_if.mem_wdata, 64'd0);
        check_eq("midrst.valM", valM, 64'd0);
        rst_n = 1'b1;
        tick();
        do_op("post_rst", 4'h5, 64'd0, 64'd32, 64'd0, 2, 64'h4242, 1, 0, 64'd32, 64'd0, 3, 64'h4242, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
